interrupt_ack_sequencer: RTL and testbench
==========================================

INTERRUPT_ACK_SEQUENCER -- requirements
Module: interrupt_ack_sequencer

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255, the number of cycles allowed between first and second inta pulse before abort.
REQ-002 SHALL have port clk  input  1  single clock for all state; rising edge.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 SHALL have port irq_in  input  8  level interrupt request lines IR0..IR7.
REQ-005 SHALL have port interrupt_mask  input  8  mask bits; 1 = level masked.
REQ-006 SHALL have port inta  input  1  acknowledge strobe, one-cycle pulse per INTA.
REQ-007 SHALL have port eoi_valid  input  1  one-cycle EOI command strobe.
REQ-008 SHALL have port eoi_specific  input  1  1 = specific EOI, 0 = non-specific.
REQ-009 SHALL have port eoi_level  input  3  level for specific EOI.
REQ-010 SHALL have port eoi_rotate  input  1  rotate priority on this EOI.
REQ-011 SHALL have port vector_base  input  5  upper vector bits T7..T3.
REQ-012 SHALL have port int_out  output  1  interrupt request to CPU.
REQ-013 SHALL have port data_out  output  8  vector byte; data_oe  output  1  vector valid.
REQ-014 SHALL have ports interrupt_request_register / in_service_register  output  8 each  IRR and ISR state.

Function
REQ-015 SHALL run FSM IDLE -> PENDING -> ACK1 -> IDLE: IDLE->PENDING when int_out rises; PENDING->ACK1 on inta; ACK1->IDLE on second inta or timeout.
REQ-016 SHALL load IRR from irq_in every cycle in IDLE/PENDING; IRR frozen in ACK1.
REQ-017 SHALL define priority order starting at level (lowest_ptr+1) mod 8; lowest_ptr resets to 7 (IR0 highest).
REQ-018 SHALL assert int_out, registered with 1-cycle latency, when an unmasked IRR bit outranks every set ISR bit (fully nested); deassert in ACK1.
REQ-019 SHALL, on first inta in PENDING, select the highest-priority unmasked IRR level L, set ISR[L], clear IRR[L].
REQ-020 SHALL, if no unmasked IRR bit exists at first inta, flag spurious: no ISR change, L = 7.
REQ-021 SHALL, on second inta in ACK1, drive data_out = {vector_base, L} with data_oe = 1 for exactly that cycle; data_oe = 0 otherwise.
REQ-022 SHALL abort to IDLE with no vector after ACK_TIMEOUT cycles in ACK1 without inta; ISR bit stays set.
REQ-023 SHALL, on non-specific EOI, clear the highest-priority set ISR bit; no-op if ISR = 0.
REQ-024 SHALL, on specific EOI, clear ISR[eoi_level]; no-op if already 0.
REQ-025 SHALL, when eoi_rotate = 1 and a bit was cleared, set lowest_ptr to the cleared level.
REQ-026 SHALL give EOI priority over ISR set when both target the same cycle; both apply if different bits.
REQ-027 SHALL ignore inta in IDLE.

Reset
REQ-028 SHALL on reset clear IRR, ISR, int_out, data_out, data_oe, timeout counter; state IDLE; lowest_ptr = 7.
REQ-029 SHALL let reset mid-acknowledge abandon the cycle with no vector output.

Configuration
REQ-030 SHALL, with PIC_AUTO_EOI_EN defined, clear ISR[L] in the cycle after the second inta (non-spurious); eoi_rotate then rotates lowest_ptr to L.
REQ-031 SHALL, without PIC_AUTO_EOI_EN, leave ISR clearing to EOI commands only.

Structure
REQ-032 SHALL place state enum, level width (3), vector width constants in shared package pic_pkg.
REQ-033 SHALL implement rotating one-hot priority selection as sub-module priority_pick (inputs request, lowest_ptr; outputs one-hot, index, valid).

Verification
REQ-034 SHALL test: reset, irq_in = 0x24, mask 0 -> int_out 1; two inta -> data_out = {vector_base,3'd2}, ISR = 0x04.
REQ-035 SHALL test: ISR = 0x04, irq_in = 0x01 -> int_out 1; irq_in = 0x08 only -> int_out 0.
REQ-036 SHALL test: irq_in drops to 0 between int_out and first inta -> vector level 7, ISR unchanged.
REQ-037 SHALL test: ISR = 0x14, non-specific EOI with eoi_rotate = 1 -> ISR = 0x10, lowest_ptr = 2, IR3 now highest.
REQ-038 SHALL test: first inta then no second inta for ACK_TIMEOUT cycles -> IDLE, data_oe never 1.
REQ-039 SHALL test: PIC_AUTO_EOI_EN build, full acknowledge of IR5 -> ISR = 0 one cycle after second inta.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt acknowledge sequencer: sequencer
// states, level/vector widths and the rotating-priority rank helper.
package pic_pkg;

  localparam int LEVEL_W    = 3;
  localparam int NUM_LEVELS = 8;
  localparam int BASE_W     = 5;
  localparam int VECTOR_W   = BASE_W + LEVEL_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ACK1    = 2'd2
  } pic_state_e;

  // Rank 0 is the highest priority: the level just above lowest_ptr.
  function automatic logic [LEVEL_W-1:0] level_rank(
    input logic [LEVEL_W-1:0] level,
    input logic [LEVEL_W-1:0] lowest_ptr
  );
    return level - lowest_ptr - LEVEL_W'(1);
  endfunction

endpackage

// File: rtl/priority_pick.sv
// Rotating priority selector: returns the highest-priority set request bit,
// where priority starts at (lowest_ptr + 1) mod 8 and wraps around.
module priority_pick
  import pic_pkg::*;
(
  input  logic [NUM_LEVELS-1:0] request,
  input  logic [LEVEL_W-1:0]    lowest_ptr,
  output logic [NUM_LEVELS-1:0] onehot,
  output logic [LEVEL_W-1:0]    index,
  output logic                  valid
);

  logic [LEVEL_W-1:0] lvl;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    onehot = '0;
    index  = '0;
    valid  = 1'b0;
    lvl    = '0;
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      lvl = lowest_ptr + LEVEL_W'(i) + LEVEL_W'(1);
      if (request[lvl]) begin
        valid  = 1'b1;
        index  = lvl;
        onehot = NUM_LEVELS'(1) << lvl;
      end
    end
  end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259-style interrupt acknowledge sequencer: latches requests into IRR,
// raises int_out for requests that outrank everything in service, moves the
// winner into ISR on the first INTA and presents the vector on the second.
// Optional build macro PIC_AUTO_EOI_EN: the second INTA also retires the
// acknowledged level from ISR (automatic end-of-interrupt).
module interrupt_ack_sequencer
  import pic_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irq_in,
  input  logic [7:0] interrupt_mask,
  input  logic       inta,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       eoi_rotate,
  input  logic [4:0] vector_base,
  output logic       int_out,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [7:0] interrupt_request_register,
  output logic [7:0] in_service_register
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  pic_state_e           state_q, state_d;
  logic [7:0]           irr_q, irr_d;
  logic [7:0]           isr_q, isr_d;
  logic                 int_out_q, int_out_d;
  logic [VECTOR_W-1:0]  data_out_q, data_out_d;
  logic                 data_oe_q, data_oe_d;
  logic [LEVEL_W-1:0]   lowest_ptr_q, lowest_ptr_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [CNT_W-1:0]     tmo_cnt_q, tmo_cnt_d;
`ifdef PIC_AUTO_EOI_EN
  logic                 spurious_q, spurious_d;
`endif

  logic [7:0]         req_masked;
  logic [7:0]         req_onehot, isr_onehot;
  logic [LEVEL_W-1:0] req_idx, isr_idx;
  logic               req_valid, isr_valid;
  logic               outranks;
  logic [7:0]         isr_set, eoi_clr, auto_clr;
  logic               clr_hit;
  logic [LEVEL_W-1:0] clr_lvl;

  assign req_masked = irr_q & ~interrupt_mask;

  priority_pick u_req_pick (
    .request    (req_masked),
    .lowest_ptr (lowest_ptr_q),
    .onehot     (req_onehot),
    .index      (req_idx),
    .valid      (req_valid)
  );

  priority_pick u_isr_pick (
    .request    (isr_q),
    .lowest_ptr (lowest_ptr_q),
    .onehot     (isr_onehot),
    .index      (isr_idx),
    .valid      (isr_valid)
  );

  // Fully nested: a request only interrupts if it beats every in-service level.
  assign outranks = req_valid &&
                    (!isr_valid ||
                     (level_rank(req_idx, lowest_ptr_q) < level_rank(isr_idx, lowest_ptr_q)));

  // Next-state logic for the acknowledge sequence, ISR/IRR and EOI handling.
  always_comb begin
    state_d      = state_q;
    irr_d        = irr_q;
    lowest_ptr_d = lowest_ptr_q;
    level_d      = level_q;
    tmo_cnt_d    = tmo_cnt_q;
    data_out_d   = '0;
    data_oe_d    = 1'b0;
    isr_set      = '0;
    eoi_clr      = '0;
    auto_clr     = '0;
    clr_hit      = 1'b0;
    clr_lvl      = '0;
`ifdef PIC_AUTO_EOI_EN
    spurious_d   = spurious_q;
`endif

    case (state_q)
      ST_IDLE: begin
        irr_d = irq_in;
        if (outranks) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        irr_d = irq_in;
        if (inta) begin
          state_d   = ST_ACK1;
          tmo_cnt_d = '0;
          if (req_valid) begin
            isr_set = req_onehot;
            irr_d   = irq_in & ~req_onehot;
            level_d = req_idx;
          end else begin
            level_d = LEVEL_W'(7);
          end
`ifdef PIC_AUTO_EOI_EN
          spurious_d = !req_valid;
`endif
        end
      end
      ST_ACK1: begin
        if (inta) begin
          state_d    = ST_IDLE;
          data_out_d = {vector_base, level_q};
          data_oe_d  = 1'b1;
        end else if (tmo_cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A specific EOI always masks a same-cycle set of that level.
    if (eoi_valid) begin
      if (eoi_specific) begin
        eoi_clr = NUM_LEVELS'(1) << eoi_level;
        clr_hit = isr_q[eoi_level] | isr_set[eoi_level];
        clr_lvl = eoi_level;
      end else if (isr_valid) begin
        eoi_clr = isr_onehot;
        clr_hit = 1'b1;
        clr_lvl = isr_idx;
      end
      if (clr_hit && eoi_rotate) lowest_ptr_d = clr_lvl;
    end

`ifdef PIC_AUTO_EOI_EN
    if (state_q == ST_ACK1 && inta && !spurious_q) begin
      auto_clr = NUM_LEVELS'(1) << level_q;
      if (eoi_rotate) lowest_ptr_d = level_q;
    end
`endif

    isr_d     = (isr_q | isr_set) & ~eoi_clr & ~auto_clr;
    int_out_d = outranks && (state_d != ST_ACK1);
  end

  // State and output registers; reset abandons any acknowledge in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      irr_q        <= '0;
      isr_q        <= '0;
      int_out_q    <= 1'b0;
      data_out_q   <= '0;
      data_oe_q    <= 1'b0;
      lowest_ptr_q <= LEVEL_W'(7);
      level_q      <= '0;
      tmo_cnt_q    <= '0;
`ifdef PIC_AUTO_EOI_EN
      spurious_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      irr_q        <= irr_d;
      isr_q        <= isr_d;
      int_out_q    <= int_out_d;
      data_out_q   <= data_out_d;
      data_oe_q    <= data_oe_d;
      lowest_ptr_q <= lowest_ptr_d;
      level_q      <= level_d;
      tmo_cnt_q    <= tmo_cnt_d;
`ifdef PIC_AUTO_EOI_EN
      spurious_q   <= spurious_d;
`endif
    end
  end

  assign int_out                    = int_out_q;
  assign data_out                   = data_out_q;
  assign data_oe                    = data_oe_q;
  assign interrupt_request_register = irr_q;
  assign in_service_register        = isr_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Testbench for interrupt_ack_sequencer: table-driven cycle vectors plus
// hand-written timeout, reset-abort and auto-EOI sequences; delivered vectors
// are checked against a queue of expected vectors.
module tb_interrupt_ack_sequencer;

  localparam int T = 6;
  localparam logic [4:0] VB = 5'b10101;

  logic       clk;
  logic       reset;
  logic [7:0] irq_in;
  logic [7:0] interrupt_mask;
  logic       inta;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       eoi_rotate;
  logic [4:0] vector_base;
  logic       int_out;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] irr;
  logic [7:0] isr;

  typedef struct {
    logic [7:0] irq;
    logic [7:0] mask;
    logic       a;
    logic       ev;
    logic       es;
    logic [2:0] el;
    logic       er;
    logic       chk;
    logic       eint;
    logic [7:0] eisr;
    logic       push;
    logic [2:0] lvl;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         oe_cnt   = 0;
  int         oe_before;

  interrupt_ack_sequencer #(.ACK_TIMEOUT(T)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .irq_in                     (irq_in),
    .interrupt_mask             (interrupt_mask),
    .inta                       (inta),
    .eoi_valid                  (eoi_valid),
    .eoi_specific               (eoi_specific),
    .eoi_level                  (eoi_level),
    .eoi_rotate                 (eoi_rotate),
    .vector_base                (vector_base),
    .int_out                    (int_out),
    .data_out                   (data_out),
    .data_oe                    (data_oe),
    .interrupt_request_register (irr),
    .in_service_register        (isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] irq, input logic [7:0] msk, input logic a,
                       input logic ev, input logic es, input logic [2:0] el, input logic er);
    irq_in         = irq;
    interrupt_mask = msk;
    inta           = a;
    eoi_valid      = ev;
    eoi_specific   = es;
    eoi_level      = el;
    eoi_rotate     = er;
  endtask

  task automatic add(input logic [7:0] irq, input logic [7:0] msk, input logic a,
                     input logic ev, input logic es, input logic [2:0] el, input logic er,
                     input logic chk, input logic eint, input logic [7:0] eisr,
                     input logic push, input logic [2:0] lvl);
    vec_t v;
    v.irq = irq; v.mask = msk; v.a = a; v.ev = ev; v.es = es; v.el = el; v.er = er;
    v.chk = chk; v.eint = eint; v.eisr = eisr; v.push = push; v.lvl = lvl;
    tbl.push_back(v);
  endtask

  // Every delivered vector must match the oldest expected one.
  always @(negedge clk) begin
    if (data_oe === 1'b1) begin
      oe_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_vector: data_out=0x%0h with data_oe=1, expected no vector", data_out);
      end else begin
        exp_v = exp_q.pop_front();
        if (data_out !== exp_v) begin
          n_fail++;
          $display("FAIL vector: got 0x%0h, expected 0x%0h", data_out, exp_v);
        end
      end
    end
  end

  initial begin
    vector_base = VB;
    reset       = 1'b1;
    drive(8'h00, 8'h00, 0, 0, 0, 3'd0, 0);
    step();
    step();
    check("reset_int_out", {7'd0, int_out}, 8'h00);
    check("reset_data_oe", {7'd0, data_oe}, 8'h00);
    check("reset_data_out", data_out, 8'h00);
    check("reset_isr", isr, 8'h00);
    check("reset_irr", irr, 8'h00);
    reset = 1'b0;

`ifndef PIC_AUTO_EOI_EN
    //   irq    mask  a  ev es el    er chk int isr    push lvl
    // IR2 of 0x24 acknowledged, vector level 2, ISR 0x04
    add(8'h24, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 8'h00, 0, 3'd0);
    add(8'h24, 8'h00, 0, 0, 0, 3'd0, 0, 1, 1, 8'h00, 0, 3'd0);
    add(8'h24, 8'h00, 0, 0, 0, 3'd0, 0, 1, 1, 8'h00, 0, 3'd0);
    add(8'h24, 8'h00, 1, 0, 0, 3'd0, 0, 1, 0, 8'h04, 0, 3'd0);
    add(8'h24, 8'h00, 1, 0, 0, 3'd0, 0, 1, 0, 8'h04, 1, 3'd2);
    add(8'h00, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 8'h00, 0, 3'd0);
    // nesting: IR3 blocked by IR2 in service, IR0 gets through
    add(8'h08, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 8'h00, 0, 3'd0);
    add(8'h08, 8'h00, 0, 0, 0, 3'd0, 0, 1, 0, 8'h04, 0, 3'd0);
    add(8'h01, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 8'h00, 0, 3'd0);
    add(8'h01, 8'h00, 0, 0, 0, 3'd0, 0, 1, 1, 8'h04, 0, 3'd0);
    add(8'h01, 8'h00, 1, 0, 0, 3'd0, 0, 1, 0, 8'h05, 0, 3'd0);
    add(8'h01, 8'h00, 1, 0, 0, 3'd0, 0, 1, 0, 8'h05, 1, 3'd0);
    add(8'h00, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 8'h00, 0, 3'd0);
    // EOIs: non-specific clears IR0, specific clears IR2, specific on empty level is a no-op
    add(8'h00, 8'h00, 0, 1, 0, 3'd0, 0, 1, 0, 8'h04, 0, 3'd0);
    add(8'h00, 8'h00, 0, 1, 1, 3'd2, 0, 1, 0, 8'h00, 0, 3'd0);
    add(8'h00, 8'h00, 0, 1, 1, 3'd7, 1, 1, 0, 8'h00, 0, 3'd0);
    // masked request stays quiet
    add(8'h02, 8'h02, 0, 0, 0, 3'd0, 0, 0, 0, 8'h00, 0, 3'd0);
    add(8'h02, 8'h02, 0, 0, 0, 3'd0, 0, 1, 0, 8'h00, 0, 3'd0);
    // unmask, then request vanishes before INTA: spurious level 7, ISR untouched
    add(8'h02, 8'h00, 0, 0, 0, 3'd0, 0, 1, 1, 8'h00, 0, 3'd0);
    add(8'h02, 8'h00, 0, 0, 0, 3'd0, 0, 1, 1, 8'h00, 0, 3'd0);
    add(8'h00, 8'h00, 0, 0, 0, 3'd0, 0, 1, 1, 8'h00, 0, 3'd0);
    add(8'h00, 8'h00, 0, 0, 0, 3'd0, 0, 1, 0, 8'h00, 0, 3'd0);
    add(8'h00, 8'h00, 1, 0, 0, 3'd0, 0, 1, 0, 8'h00, 0, 3'd0);
    add(8'h00, 8'h00, 1, 0, 0, 3'd0, 0, 1, 0, 8'h00, 1, 3'd7);
    add(8'h00, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 8'h00, 0, 3'd0);
    // build ISR 0x14: IR4 then nested IR2
    add(8'h10, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 8'h00, 0, 3'd0);
    add(8'h10, 8'h00, 0, 0, 0, 3'd0, 0, 1, 1, 8'h00, 0, 3'd0);
    add(8'h10, 8'h00, 1, 0, 0, 3'd0, 0, 1, 0, 8'h10, 0, 3'd0);
    add(8'h10, 8'h00, 1, 0, 0, 3'd0, 0, 1, 0, 8'h10, 1, 3'd4);
    add(8'h04, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 8'h00, 0, 3'd0);
    add(8'h04, 8'h00, 0, 0, 0, 3'd0, 0, 1, 1, 8'h10, 0, 3'd0);
    add(8'h04, 8'h00, 1, 0, 0, 3'd0, 0, 1, 0, 8'h14, 0, 3'd0);
    add(8'h04, 8'h00, 1, 0, 0, 3'd0, 0, 1, 0, 8'h14, 1, 3'd2);
    // rotating non-specific EOI: clears IR2, IR3 becomes highest
    add(8'h00, 8'h00, 0, 1, 0, 3'd0, 1, 1, 0, 8'h10, 0, 3'd0);
    add(8'h01, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 8'h00, 0, 3'd0);
    add(8'h01, 8'h00, 0, 0, 0, 3'd0, 0, 1, 0, 8'h10, 0, 3'd0);
    add(8'h09, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 8'h00, 0, 3'd0);
    add(8'h09, 8'h00, 0, 0, 0, 3'd0, 0, 1, 1, 8'h10, 0, 3'd0);
    add(8'h09, 8'h00, 1, 0, 0, 3'd0, 0, 1, 0, 8'h18, 0, 3'd0);
    add(8'h09, 8'h00, 1, 0, 0, 3'd0, 0, 1, 0, 8'h18, 1, 3'd3);
    add(8'h00, 8'h00, 0, 0, 0, 3'd0, 0, 1, 0, 8'h18, 0, 3'd0);
    add(8'h00, 8'h00, 0, 1, 0, 3'd0, 0, 1, 0, 8'h10, 0, 3'd0);
    add(8'h00, 8'h00, 0, 1, 1, 3'd4, 0, 1, 0, 8'h00, 0, 3'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].irq, tbl[i].mask, tbl[i].a, tbl[i].ev, tbl[i].es, tbl[i].el, tbl[i].er);
      if (tbl[i].push) exp_q.push_back({VB, tbl[i].lvl});
      step();
      if (tbl[i].chk) begin
        check($sformatf("row%0d_int_out", i), {7'd0, int_out}, {7'd0, tbl[i].eint});
        check($sformatf("row%0d_isr", i), isr, tbl[i].eisr);
      end
    end

    // second INTA on the last cycle before the timeout still delivers
    drive(8'h40, 8'h00, 0, 0, 0, 3'd0, 0);
    step();
    step();
    check("toa_int_out", {7'd0, int_out}, 8'h01);
    drive(8'h40, 8'h00, 1, 0, 0, 3'd0, 0);
    step();
    check("toa_isr", isr, 8'h40);
    drive(8'h40, 8'h00, 0, 0, 0, 3'd0, 0);
    repeat (T - 1) step();
    check("toa_int_low_in_ack1", {7'd0, int_out}, 8'h00);
    drive(8'h40, 8'h00, 1, 0, 0, 3'd0, 0);
    exp_q.push_back({VB, 3'd6});
    step();
    drive(8'h00, 8'h00, 0, 0, 0, 3'd0, 0);
    step();
    drive(8'h00, 8'h00, 0, 1, 1, 3'd6, 0);
    step();
    check("toa_eoi_isr", isr, 8'h00);

    // no second INTA for ACK_TIMEOUT cycles: abort, later INTA ignored
    drive(8'h40, 8'h00, 0, 0, 0, 3'd0, 0);
    step();
    step();
    check("tob_int_out", {7'd0, int_out}, 8'h01);
    drive(8'h40, 8'h00, 1, 0, 0, 3'd0, 0);
    step();
    oe_before = oe_cnt;
    drive(8'h40, 8'h00, 0, 0, 0, 3'd0, 0);
    repeat (T) step();
    drive(8'h40, 8'h00, 1, 0, 0, 3'd0, 0);
    step();
    drive(8'h40, 8'h00, 0, 0, 0, 3'd0, 0);
    step();
    check("tob_no_vector", 8'(oe_cnt - oe_before), 8'h00);
    check("tob_isr_kept", isr, 8'h40);
    check("tob_int_out_low", {7'd0, int_out}, 8'h00);
    drive(8'h00, 8'h00, 0, 0, 0, 3'd0, 0);
    step();
    drive(8'h00, 8'h00, 0, 1, 1, 3'd6, 0);
    step();
    check("tob_eoi_isr", isr, 8'h00);
`endif

    // reset in the middle of an acknowledge
    drive(8'h01, 8'h00, 0, 0, 0, 3'd0, 0);
    step();
    step();
    check("rst_ack_int_out", {7'd0, int_out}, 8'h01);
    drive(8'h01, 8'h00, 1, 0, 0, 3'd0, 0);
    step();
    check("rst_ack_isr_set", isr, 8'h01);
    oe_before = oe_cnt;
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(8'h00, 8'h00, 0, 0, 0, 3'd0, 0);
    check("rst_ack_isr", isr, 8'h00);
    check("rst_ack_irr", irr, 8'h00);
    check("rst_ack_int_out_low", {7'd0, int_out}, 8'h00);
    step();
    drive(8'h00, 8'h00, 1, 0, 0, 3'd0, 0);
    step();
    drive(8'h00, 8'h00, 0, 0, 0, 3'd0, 0);
    step();
    check("rst_ack_no_vector", 8'(oe_cnt - oe_before), 8'h00);

    // full acknowledge of IR5
    drive(8'h20, 8'h00, 0, 0, 0, 3'd0, 0);
    step();
    step();
    check("ir5_int_out", {7'd0, int_out}, 8'h01);
    drive(8'h20, 8'h00, 1, 0, 0, 3'd0, 0);
    step();
    check("ir5_isr_set", isr, 8'h20);
    drive(8'h00, 8'h00, 1, 0, 0, 3'd0, 0);
    exp_q.push_back({VB, 3'd5});
    step();
`ifdef PIC_AUTO_EOI_EN
    check("ir5_isr_after_ack", isr, 8'h00);
`else
    check("ir5_isr_after_ack", isr, 8'h20);
`endif
    drive(8'h00, 8'h00, 0, 0, 0, 3'd0, 0);
    step();
    step();

    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
